// File: rtl/ice_wait_flerr_ctl.sv
// ice_wait_flerr_ctl: combines the ICE wait requests into one CPU wait, with an
// optional wait-timeout FSM, a stretched status-LED wait indication, and a
// sticky flash-error flag that snapshots the error sources.
// Build option: define ICE_WAIT_TIMEOUT_EN to add the timeout FSM, the timeout
// counter and the WAITTO flag. Without it WAITOR is the plain OR of WAITREQ and
// WAITTO is tied low.
module ice_wait_flerr_ctl #(
   parameter int NWAIT  = 2,
   parameter int NFLERR = 2,
   parameter int TOW    = 16,
   parameter int STRW   = 4
) (
   input  logic              CLK30MHZ_GB,
   input  logic              ICERESET,
   input  logic [NWAIT-1:0]  WAITREQ,
   input  logic [TOW-1:0]    TOLIMIT,
   output logic              WAITOR,
   output logic              WAITTO,
   input  logic              WAITTO_CLR,
   output logic              ELEDWAIT_B,
   input  logic [NFLERR-1:0] FLERR_IN,
   output logic              ICEFLERR,
   output logic              FLERR_STK,
   output logic [NFLERR-1:0] FLERR_SRC,
   input  logic              FLERR_CLR
);

   logic              w_raw_wait;
   logic              w_flerr_cap;
   logic              w_led_on;
   logic [STRW-1:0]   r_str_cnt;
   logic              r_flerr_stk;
   logic [NFLERR-1:0] r_flerr_src;

   assign w_raw_wait = |WAITREQ;
   assign ICEFLERR   = |FLERR_IN;

`ifdef ICE_WAIT_TIMEOUT_EN
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAITING = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam logic [TOW-1:0] TO_ONE = {{(TOW-1){1'b0}}, 1'b1};
   localparam logic [TOW-1:0] TO_MAX = {TOW{1'b1}};

   logic [1:0]     r_state;
   logic [TOW-1:0] r_to_cnt;
   logic           r_waitto;
   logic           w_to_hit;

   // Timeout fires only while still waiting; a zero limit means "never".
   // The limit is read live, so lowering it to 0 cancels a pending timeout.
   assign w_to_hit = (r_state == ST_WAITING) && w_raw_wait &&
                     (TOLIMIT != '0) && (r_to_cnt == TOLIMIT);

   // Wait FSM and timeout counter; RELEASE hides the wait from the CPU until
   // every requester has dropped its request.
   always_ff @(posedge CLK30MHZ_GB or posedge ICERESET) begin
      if (ICERESET) begin
         r_state  <= ST_IDLE;
         r_to_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_raw_wait) begin
                  r_state  <= ST_WAITING;
                  r_to_cnt <= TO_ONE;
               end
            end
            ST_WAITING: begin
               if (!w_raw_wait) begin
                  r_state  <= ST_IDLE;
                  r_to_cnt <= '0;
               end else if (w_to_hit) begin
                  r_state  <= ST_RELEASE;
                  r_to_cnt <= '0;
               end else if (r_to_cnt != TO_MAX) begin
                  r_to_cnt <= r_to_cnt + TO_ONE;
               end
            end
            ST_RELEASE: begin
               r_to_cnt <= '0;
               if (!w_raw_wait) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_to_cnt <= '0;
            end
         endcase
      end
   end

   // Sticky timeout flag; a set in the same cycle as a clear takes priority.
   always_ff @(posedge CLK30MHZ_GB or posedge ICERESET) begin
      if (ICERESET) begin
         r_waitto <= 1'b0;
      end else if (w_to_hit) begin
         r_waitto <= 1'b1;
      end else if (WAITTO_CLR) begin
         r_waitto <= 1'b0;
      end
   end

   assign WAITOR = w_raw_wait && (r_state != ST_RELEASE);
   assign WAITTO = r_waitto;
`else
   logic w_unused_timeout;

   // Timeout inputs have no function in this build.
   assign w_unused_timeout = ^{TOLIMIT, WAITTO_CLR};
   assign WAITOR           = w_raw_wait;
   assign WAITTO           = 1'b0;
`endif

   // LED stretch: reload to all-ones while any wait is active, then count down
   // so the LED stays on for 2**STRW-1 cycles after the wait ends.
   always_ff @(posedge CLK30MHZ_GB or posedge ICERESET) begin
      if (ICERESET) begin
         r_str_cnt <= '0;
      end else if (w_raw_wait) begin
         r_str_cnt <= '1;
      end else if (r_str_cnt != '0) begin
         r_str_cnt <= r_str_cnt - {{(STRW-1){1'b0}}, 1'b1};
      end
   end

   // Reset gates the live wait term so the LED is dark while in reset.
   assign w_led_on   = (w_raw_wait && !ICERESET) || (r_str_cnt != '0);
   assign ELEDWAIT_B = !w_led_on;

   // Capture on the first error, or on an error coinciding with a clear, so
   // the snapshot always reflects the error that re-armed the flag.
   assign w_flerr_cap = ICEFLERR && (!r_flerr_stk || FLERR_CLR);

   // Sticky flash-error flag and source snapshot.
   always_ff @(posedge CLK30MHZ_GB or posedge ICERESET) begin
      if (ICERESET) begin
         r_flerr_stk <= 1'b0;
         r_flerr_src <= '0;
      end else if (w_flerr_cap) begin
         r_flerr_stk <= 1'b1;
         r_flerr_src <= FLERR_IN;
      end else if (FLERR_CLR) begin
         r_flerr_stk <= 1'b0;
         r_flerr_src <= '0;
      end
   end

   assign FLERR_STK = r_flerr_stk;
   assign FLERR_SRC = r_flerr_src;

endmodule

// File: tb/tb_ice_wait_flerr_ctl.sv
// Testbench for ice_wait_flerr_ctl (default parameters). Inputs change just
// after the rising edge, outputs are checked mid-cycle. Expectations for the
// timeout path depend on whether ICE_WAIT_TIMEOUT_EN is defined.
module tb_ice_wait_flerr_ctl;

   logic        clk;
   logic        rst;
   logic [1:0]  waitreq;
   logic [15:0] tolimit;
   logic        waitto_clr;
   logic [1:0]  flerr_in;
   logic        flerr_clr;
   logic        waitor;
   logic        waitto;
   logic        eledwait_b;
   logic        iceflerr;
   logic        flerr_stk;
   logic [1:0]  flerr_src;

   int total;
   int bad;

   ice_wait_flerr_ctl #(.NWAIT(2), .NFLERR(2), .TOW(16), .STRW(4)) dut (
      .CLK30MHZ_GB (clk),
      .ICERESET    (rst),
      .WAITREQ     (waitreq),
      .TOLIMIT     (tolimit),
      .WAITOR      (waitor),
      .WAITTO      (waitto),
      .WAITTO_CLR  (waitto_clr),
      .ELEDWAIT_B  (eledwait_b),
      .FLERR_IN    (flerr_in),
      .ICEFLERR    (iceflerr),
      .FLERR_STK   (flerr_stk),
      .FLERR_SRC   (flerr_src),
      .FLERR_CLR   (flerr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ICE_WAIT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      logic [1:0] wr;
      logic [1:0] fl;
      logic       fclr;
      logic       e_waitor;
      logic       e_led_b;
      logic       e_icefl;
      logic       e_stk;
      logic [1:0] e_src;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      waitreq = 2'b00; flerr_in = 2'b00; flerr_clr = 1'b0; waitto_clr = 1'b0;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int errs;
      total = 0;
      bad   = 0;
      rst = 1'b1; waitreq = 2'b00; tolimit = 16'd0; waitto_clr = 1'b0;
      flerr_in = 2'b00; flerr_clr = 1'b0;

      // per-cycle table: {WAITREQ, FLERR_IN, FLERR_CLR, WAITOR, ELEDWAIT_B, ICEFLERR, STK, SRC}
      vecs[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      vecs[1] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[2] = '{2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
      vecs[3] = '{2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10};
      vecs[4] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
      vecs[5] = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[6] = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      vecs[7] = '{2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11};
      vecs[8] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};

      // Reset state, with live inputs still passing through combinationally.
      tick();
      waitreq = 2'b01; flerr_in = 2'b10;
      #1;
      chk("rst_waitor", waitor, 1'b1);
      chk("rst_waitto", waitto, 1'b0);
      chk("rst_led_b", eledwait_b, 1'b1);
      chk("rst_iceflerr", iceflerr, 1'b1);
      chk("rst_stk", flerr_stk, 1'b0);
      chk("rst_src", flerr_src, 2'b00);
      $display("txn reset: waitor=%b waitto=%b led_b=%b stk=%b", waitor, waitto, eledwait_b, flerr_stk);
      do_reset();

      // Table-driven: wait OR, LED stretch restart, flash-error capture/clear.
      for (int i = 0; i < 9; i++) begin
         waitreq = vecs[i].wr; flerr_in = vecs[i].fl; flerr_clr = vecs[i].fclr;
         #1;
         chk($sformatf("vec%0d_waitor", i), waitor, vecs[i].e_waitor);
         chk($sformatf("vec%0d_waitto", i), waitto, 1'b0);
         chk($sformatf("vec%0d_led_b", i), eledwait_b, vecs[i].e_led_b);
         chk($sformatf("vec%0d_iceflerr", i), iceflerr, vecs[i].e_icefl);
         chk($sformatf("vec%0d_stk", i), flerr_stk, vecs[i].e_stk);
         chk($sformatf("vec%0d_src", i), flerr_src, vecs[i].e_src);
         $display("txn vec%0d: wr=%b fl=%b clr=%b -> waitor=%b led_b=%b stk=%b src=%b",
                  i, vecs[i].wr, vecs[i].fl, vecs[i].fclr, waitor, eledwait_b, flerr_stk, flerr_src);
         tick();
      end

      // Short wait, no timeout: WAITOR 5 cycles, LED low 5+15 cycles.
      do_reset();
      tolimit = 16'd10;
      for (int c = 0; c < 23; c++) begin
         waitreq = (c < 5) ? 2'b01 : 2'b00;
         #1;
         chk($sformatf("short_c%0d_waitor", c), waitor, (c < 5) ? 1'b1 : 1'b0);
         chk($sformatf("short_c%0d_led_b", c), eledwait_b, (c < 20) ? 1'b0 : 1'b1);
         chk($sformatf("short_c%0d_waitto", c), waitto, 1'b0);
         tick();
      end
      $display("txn short_wait: 5 wait cycles, stretch checked");

      // Held wait, TOLIMIT=8: release after 9 cycles; clear collides with set.
      do_reset();
      tolimit = 16'd8;
      for (int c = 0; c < 24; c++) begin
         waitreq    = (c < 20 || c == 21) ? 2'b10 : 2'b00;
         waitto_clr = (c == 8 || c == 22) ? 1'b1 : 1'b0;
         #1;
         if (TO_EN) begin
            chk($sformatf("to8_c%0d_waitor", c), waitor,
                (c < 9 || c == 21) ? 1'b1 : 1'b0);
            chk($sformatf("to8_c%0d_waitto", c), waitto,
                (c >= 9 && c <= 22) ? 1'b1 : 1'b0);
         end else begin
            chk($sformatf("to8_c%0d_waitor", c), waitor, (c < 20 || c == 21) ? 1'b1 : 1'b0);
            chk($sformatf("to8_c%0d_waitto", c), waitto, 1'b0);
         end
         tick();
      end
      waitto_clr = 1'b0;
      $display("txn timeout8: en=%b waitto=%b", TO_EN, waitto);

      // TOLIMIT=0 for 70000 cycles: never times out, counter must saturate.
      do_reset();
      tolimit = 16'd0;
      waitreq = 2'b01;
      errs = 0;
      for (int c = 0; c < 70000; c++) begin
         #1;
         if (waitor !== 1'b1 || waitto !== 1'b0) errs++;
         tick();
      end
      chk("long_bad_cycles", errs, 0);
      // Saturated counter equals a freshly raised all-ones limit at once.
      tolimit = 16'hFFFF;
      #1;
      chk("sat_hit_waitor", waitor, 1'b1);
      tick();
      #1;
      chk("sat_after_waitor", waitor, TO_EN ? 1'b0 : 1'b1);
      chk("sat_after_waitto", waitto, TO_EN);
      $display("txn long_wait: errs=%0d waitor_after=%b", errs, waitor);

      // Reset in RELEASE aborts everything immediately.
      do_reset();
      tolimit = 16'd4;
      flerr_in = 2'b10;
      waitreq = 2'b01;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) flerr_in = 2'b00;
         tick();
      end
      #1;
      chk("rel_waitor", waitor, TO_EN ? 1'b0 : 1'b1);
      chk("rel_waitto", waitto, TO_EN);
      chk("rel_stk", flerr_stk, 1'b1);
      chk("rel_led_b", eledwait_b, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_waitto", waitto, 1'b0);
      chk("arst_led_b", eledwait_b, 1'b1);
      chk("arst_waitor", waitor, 1'b1);
      chk("arst_stk", flerr_stk, 1'b0);
      chk("arst_src", flerr_src, 2'b00);
      tick();
      rst = 1'b0;
      // Fresh wait after reset: high for TOLIMIT+1 cycles, then released.
      for (int c = 0; c < 7; c++) begin
         #1;
         chk($sformatf("post_c%0d_waitor", c), waitor, (TO_EN && c >= 5) ? 1'b0 : 1'b1);
         chk($sformatf("post_c%0d_waitto", c), waitto, (TO_EN && c >= 5) ? 1'b1 : 1'b0);
         tick();
      end
      $display("txn reset_in_release: waitor=%b waitto=%b", waitor, waitto);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
